// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its RAW comparator.
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned REG_IDX_W = 4;
   localparam int unsigned WAIT_CNT_W = 8;

   // Instruction the flushed IFReg/IDReg slots are expected to hold (MOV r0, r0).
   localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ERROR = 2'd2
   } mem_state_e;

   function automatic logic src_match(
      input logic                 use_rn,
      input logic [REG_IDX_W-1:0] rn,
      input logic                 two_src,
      input logic [REG_IDX_W-1:0] rm,
      input logic [REG_IDX_W-1:0] dest
   );
      return (use_rn && (rn == dest)) || (two_src && (rm == dest));
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect_unit.sv
// Combinational RAW hazard compare between the ID sources and the EX/MEM destinations.
module hazard_detect_unit
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter bit FORWARD_EN = 1'b0
) (
   input  logic [REG_IDX_W-1:0] id_rn_i,
   input  logic [REG_IDX_W-1:0] id_rm_i,
   input  logic                 id_use_rn_i,
   input  logic                 id_two_src_i,
   input  logic [REG_IDX_W-1:0] ex_dest_i,
   input  logic                 ex_wb_en_i,
   input  logic                 ex_mem_read_i,
   input  logic [REG_IDX_W-1:0] mem_dest_i,
   input  logic                 mem_wb_en_i,
   output logic                 raw_hz_o
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = ex_wb_en_i  && src_match(id_use_rn_i, id_rn_i, id_two_src_i, id_rm_i, ex_dest_i);
   assign mem_hit = mem_wb_en_i && src_match(id_use_rn_i, id_rn_i, id_two_src_i, id_rm_i, mem_dest_i);

   // With forwarding only a load in EX cannot supply its result in time.
   if (FORWARD_EN) begin : g_fwd
      assign raw_hz_o = ex_hit && ex_mem_read_i;
   end else begin : g_no_fwd
      assign raw_hz_o = ex_hit || mem_hit;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: freeze/flush priority mux, memory-wait FSM with timeout, perf counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter bit          FORWARD_EN  = 1'b0,
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [REG_IDX_W-1:0] id_rn,
   input  logic [REG_IDX_W-1:0] id_rm,
   input  logic                 id_use_rn,
   input  logic                 id_two_src,
   input  logic [REG_IDX_W-1:0] ex_dest,
   input  logic                 ex_wb_en,
   input  logic                 ex_mem_read,
   input  logic [REG_IDX_W-1:0] mem_dest,
   input  logic                 mem_wb_en,
   input  logic                 ex_branch_taken,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   output logic                 pc_freeze,
   output logic                 if_reg_freeze,
   output logic                 if_reg_flush,
   output logic                 id_reg_freeze,
   output logic                 id_reg_flush,
   output logic                 ex_reg_freeze,
   output logic                 mem_reg_freeze,
   output logic                 mem_busy,
   output logic                 timeout_err,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};

   mem_state_e              state_q, state_d;
   logic [WAIT_CNT_W-1:0]   wait_q, wait_d;
   logic                    err_q, err_d;
   logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]        flush_cnt_q, flush_cnt_d;
   logic                    raw_hz;
   logic                    mem_stall;

   hazard_detect_unit #(.FORWARD_EN(FORWARD_EN)) u_hdu (
      .id_rn_i       (id_rn),
      .id_rm_i       (id_rm),
      .id_use_rn_i   (id_use_rn),
      .id_two_src_i  (id_two_src),
      .ex_dest_i     (ex_dest),
      .ex_wb_en_i    (ex_wb_en),
      .ex_mem_read_i (ex_mem_read),
      .mem_dest_i    (mem_dest),
      .mem_wb_en_i   (mem_wb_en),
      .raw_hz_o      (raw_hz)
   );

   assign mem_stall = mem_req && !mem_ready && (state_q != ST_ERROR);

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_stall) begin
               state_d = ST_WAIT;
               wait_d  = WAIT_CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (mem_stall && (wait_q == TIMEOUT_C)) begin
               state_d = ST_ERROR;
               err_d   = 1'b1;
            end else if (mem_stall) begin
               wait_d = wait_q + WAIT_CNT_W'(1);
            end else begin
               state_d = ST_IDLE;
               wait_d  = '0;
            end
         end
         ST_ERROR: ;
         default: begin
            state_d = ST_IDLE;
            wait_d  = '0;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held, independent of registered state.
   always_comb begin
      pc_freeze      = 1'b0;
      if_reg_freeze  = 1'b0;
      if_reg_flush   = 1'b0;
      id_reg_freeze  = 1'b0;
      id_reg_flush   = 1'b0;
      ex_reg_freeze  = 1'b0;
      mem_reg_freeze = 1'b0;
      if (!rst) begin
         if (state_q == ST_ERROR || mem_stall) begin
            pc_freeze      = 1'b1;
            if_reg_freeze  = 1'b1;
            id_reg_freeze  = 1'b1;
            ex_reg_freeze  = 1'b1;
            mem_reg_freeze = 1'b1;
         end else if (ex_branch_taken) begin
            if_reg_flush = 1'b1;
            id_reg_flush = 1'b1;
         end else if (raw_hz) begin
            pc_freeze     = 1'b1;
            if_reg_freeze = 1'b1;
            id_reg_flush  = 1'b1;
         end
      end
   end

   assign mem_busy    = mem_stall && !rst;
   assign timeout_err = err_q && !rst;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_freeze && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (if_reg_flush && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wait_q      <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
- Drives every freeze and flush input that is currently tied off on the stage and pipeline-register modules.
- Detects RAW hazards in ID, flushes IF/ID on taken branches, and stalls the whole pipeline while the MEM-stage data memory is busy.
- Contains a memory-wait FSM with timeout, plus saturating performance counters.

Parameters:
- FORWARD_EN, 0: 0 = stall on any RAW hazard against EX or MEM; 1 = stall only on load-use against EX.
- MEM_TIMEOUT, 64: maximum consecutive memory-wait cycles before the error trap (range 1..255).
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_rn  in  4  ID source register Rn
- id_rm  in  4  ID second source (Rm, or Rd for STR)
- id_use_rn  in  1  ID instruction reads Rn
- id_two_src  in  1  ID instruction reads id_rm
- ex_dest  in  4  destination register in EX
- ex_wb_en  in  1  EX instruction writes back
- ex_mem_read  in  1  EX instruction is a load
- mem_dest  in  4  destination register in MEM
- mem_wb_en  in  1  MEM instruction writes back
- ex_branch_taken  in  1  EX resolved a taken branch
- mem_req  in  1  MEM instruction performs a read or write
- mem_ready  in  1  data memory completes the access this cycle
- pc_freeze  out  1  hold PC
- if_reg_freeze  out  1  hold IFReg
- if_reg_flush  out  1  clear IFReg to NOP
- id_reg_freeze  out  1  hold IDReg
- id_reg_flush  out  1  load bubble into IDReg
- ex_reg_freeze  out  1  hold ExReg
- mem_reg_freeze  out  1  hold MemReg
- mem_busy  out  1  memory stall is active
- timeout_err  out  1  sticky error: memory never answered
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- Reset: while rst=1, all freeze/flush outputs = 0, mem_busy = 0, timeout_err = 0, counters = 0, FSM = IDLE, wait counter = 0.
- Outputs are combinational from current inputs and registered state, so a stall or flush takes effect at the same clock edge.
- raw_hz (FORWARD_EN=0): ex_wb_en and source matches ex_dest, or mem_wb_en and source matches mem_dest.
  - "source matches" means (id_use_rn and id_rn == X) or (id_two_src and id_rm == X).
- raw_hz (FORWARD_EN=1): ex_mem_read and ex_wb_en and source matches ex_dest.
- mem_stall = mem_req and not mem_ready, in state IDLE or WAIT.
- Output priority, highest first:
  1. ERROR state: all five freezes = 1, flushes = 0.
  2. mem_stall: pc_freeze, if_reg_freeze, id_reg_freeze, ex_reg_freeze, mem_reg_freeze = 1; both flushes = 0. A branch in EX is held by the frozen ExReg and flushes on the first non-stall cycle.
  3. ex_branch_taken: if_reg_flush = 1, id_reg_flush = 1, no freezes. This suppresses raw_hz, because the ID instruction is discarded.
  4. raw_hz: pc_freeze = 1, if_reg_freeze = 1, id_reg_flush = 1.
  5. Otherwise all outputs = 0.
- FSM transitions:
  - IDLE → WAIT when mem_stall; wait counter ← 1.
  - WAIT stays in WAIT while mem_stall; wait counter +1.
  - WAIT → IDLE when mem_ready (the stall drops that cycle, so the pipeline advances at that edge); wait counter ← 0.
  - WAIT → ERROR when wait counter == MEM_TIMEOUT and mem_stall. timeout_err ← 1.
  - ERROR is exited only by rst.
- mem_ready with mem_req in IDLE causes no stall and the FSM stays in IDLE.
- mem_ready without mem_req is ignored.
- mem_busy = 1 in WAIT, and in IDLE whenever mem_stall.
- stall_cnt: +1 on each cycle in which pc_freeze = 1 (any cause, including ERROR); saturates at all-ones.
- flush_cnt: +1 on each cycle in which the branch flush is applied; saturates at all-ones.
- rst asserted mid-WAIT returns the FSM to IDLE the next cycle. The pending memory access is abandoned.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_ERROR, 2-bit);
  - register-index width constant (4);
  - NOP/bubble encoding used by the flush targets.
- One sub-module, hazard_detect_unit: purely combinational RAW compare, parameterised by FORWARD_EN.
- The FSM, priority mux and counters stay in the top of this block.

Test Plan:
1. ex_dest=3, ex_wb_en=1, id_rn=3, id_use_rn=1, FORWARD_EN=0 → pc_freeze = if_reg_freeze = id_reg_flush = 1 that cycle; stall_cnt 0→1.
2. Same stimulus with FORWARD_EN=1 and ex_mem_read=0 → all outputs 0. Set ex_mem_read=1 → stall as in scenario 1.
3. raw_hz and ex_branch_taken together → only if_reg_flush = id_reg_flush = 1; flush_cnt = 1; pc_freeze = 0.
4. mem_req=1 with mem_ready low for 3 cycles, then high → all five freezes = 1 for 3 cycles, mem_busy for 3 cycles, stall_cnt = 3. An ex_branch_taken held throughout produces exactly one flush cycle after the release.
5. mem_req=1, mem_ready=0 forever, MEM_TIMEOUT=4 → ERROR after 4 wait cycles; timeout_err = 1; freezes stay 1. Asserting rst for 1 cycle clears everything to 0.
6. Hold pc_freeze continuously, CNT_W=4 → stall_cnt saturates at 15 and does not wrap.
